// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op encodings, response
// width, FSM state type, FIFO entry layout and the result packing helper.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int unsigned RSP_W   = 5;
  localparam int unsigned ENTRY_W = 1 + 2 + RSP_W;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  // One buffered response: {err, op, data}
  typedef struct packed {
    logic             err;
    logic [1:0]       op;
    logic [RSP_W-1:0] data;
  } rsp_entry_t;

  // Select and pack the ALU output group belonging to op
  function automatic logic [RSP_W-1:0] pack_result(
    input logic [1:0] op,
    input logic [3:0] y_add,
    input logic [3:0] y_sub,
    input logic [3:0] y_and,
    input logic       c_add,
    input logic       c_sub,
    input logic       agb,
    input logic       aeb,
    input logic       alb
  );
    logic [RSP_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {c_add, y_add};
      OP_SUB:  r = {c_sub, y_sub};
      OP_CMP:  r = {2'b00, agb, aeb, alb};
      default: r = {1'b0, y_and};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle of the ALU sequencer.
//   master: command producer / response consumer
//   slave : the sequencer (accepts commands, offers responses)
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_op;
  logic [RSP_W-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_rsp_fifo.sv
// Response FIFO, DEPTH entries (power of two), synchronous active-low reset.
// Ports: push/wdata write, pop/rdata read head, count/full/empty status.
// A push into an empty FIFO is not bypassed; the head appears next cycle.
module alu_rsp_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset; entries are only read while count > 0
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end and result collector for the 4-bit ALU.
// Ports: clk, rst_n (sync, active-low); bus (cmd/rsp handshakes);
//   alu_s/alu_a/alu_b registered ALU select and operands;
//   alu_y_*/alu_carry_*/alu_agb/aeb/alb ALU result groups sampled in EXEC.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [1:0] alu_s,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_y_add,
  input  logic [3:0] alu_y_sub,
  input  logic [3:0] alu_y_and,
  input  logic       alu_carry_add,
  input  logic       alu_carry_sub,
  input  logic       alu_agb,
  input  logic       alu_aeb,
  input  logic       alu_alb
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t          state;
  state_t          state_nx;
  logic            ready_c;
  logic            accept_c;
  logic            push_c;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic [1:0]      flag_sum;
  rsp_entry_t      wr_entry;
  logic [ENTRY_W-1:0] head_bits;
  rsp_entry_t      head;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake controls; ready depends only on registered state
  always_comb begin
    state_nx = state;
    ready_c  = 1'b0;
    accept_c = 1'b0;
    push_c   = 1'b0;
    case (state)
      IDLE: begin
        ready_c  = (count < CW'(DEPTH));
        accept_c = bus.cmd_valid && ready_c;
        if (accept_c) state_nx = EXEC;
      end
      EXEC: begin
        push_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ALU select/operands, loaded only on accept and held otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_s <= '0;
      alu_a <= '0;
      alu_b <= '0;
    end else if (accept_c) begin
      alu_s <= bus.cmd_op;
      alu_a <= bus.cmd_a;
      alu_b <= bus.cmd_b;
    end
  end

  // Compare flags must be exactly one-hot; anything else is flagged
  assign flag_sum = 2'(alu_agb) + 2'(alu_aeb) + 2'(alu_alb);

  always_comb begin
    wr_entry      = '0;
    wr_entry.op   = alu_s;
    wr_entry.data = pack_result(alu_s, alu_y_add, alu_y_sub, alu_y_and,
                                alu_carry_add, alu_carry_sub,
                                alu_agb, alu_aeb, alu_alb);
    wr_entry.err  = (alu_s == OP_CMP) && (flag_sum != 2'd1);
  end

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (wr_entry),
    .pop   (bus.rsp_valid && bus.rsp_ready),
    .rdata (head_bits),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign head          = rsp_entry_t'(head_bits);
  assign bus.cmd_ready = ready_c;
  assign bus.rsp_valid = !empty;
  assign bus.rsp_op    = head.op;
  assign bus.rsp_data  = head.data;
  assign bus.rsp_err   = head.err;

  // Accept is gated on free space, so a write never meets a full FIFO
  assert property (@(posedge clk) disable iff (!rst_n) !(push_c && full));

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command front-end and result collector for the 4-bit ALU. It accepts one operation per valid/ready handshake and drives the ALU's select and operand inputs from registers. One cycle later it captures the ALU output group for that operation, packs it into a 5-bit response and buffers it in a small FIFO. Downstream logic consumes the responses over a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 2, response FIFO entries; power of two, ≥2

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted on clk edge when cmd_valid && cmd_ready
- cmd_op  in  2  00 add, 01 sub, 10 compare, 11 and
- cmd_a, cmd_b  in  4  operands
- alu_s  out  2  ALU select (registered)
- alu_a, alu_b  out  4  ALU operands (registered)
- alu_y_add, alu_y_sub, alu_y_and  in  4  ALU results
- alu_carry_add, alu_carry_sub  in  1  ALU carries
- alu_agb, alu_aeb, alu_alb  in  1  ALU compare flags
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_op  out  2  op of head entry
- rsp_data  out  5  packed result of head entry
- rsp_err  out  1  head entry is a compare whose flags were not one-hot

## Operation
- FSM with two states:
  - IDLE: cmd_ready = (count < DEPTH). On accept, register cmd_op/a/b into alu_s/a/b, go to EXEC.
  - EXEC: cmd_ready = 0. The ALU settles combinationally. At the end of the cycle, write {op, data, err} into the FIFO and return to IDLE.
- Packing by the registered op:
  - 00 → {alu_carry_add, alu_y_add}
  - 01 → {alu_carry_sub, alu_y_sub}
  - 10 → {2'b00, agb, aeb, alb}
  - 11 → {1'b0, alu_y_and}
- Only the selected ALU group is sampled. The non-selected groups are zero by ALU enable gating and are ignored.
- Error flag: err = (op==10) && (agb+aeb+alb != 1). It is 0 for all other ops.
- Overflow cannot occur: a command is accepted only when count < DEPTH, and count cannot rise between accept and write.
- Pop on rsp_valid && rsp_ready.
- Push and pop in the same cycle:
  - count unchanged
  - when count==0, the push is not bypassed; rsp_valid rises the next cycle.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- rsp_op/rsp_data/rsp_err are the FIFO head. They are stable while rsp_valid && !rsp_ready.
- alu_s/a/b hold their last value in IDLE.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, count 0, pointers 0, alu_s/a/b = 0, rsp_valid 0. Because count resets to 0, cmd_ready is 1 in the first cycle after reset.
- Reset during EXEC or with FIFO content: the in-flight op and all buffered responses are discarded, with no write.
- Latency: accept at edge N → alu_* valid after N → FIFO write at N+1 → rsp_valid=1 after N+1. The response is visible 2 cycles after accept.
- Throughput: one command per 2 cycles maximum.
- When FIFO is full: cmd_ready=0 in IDLE. It reasserts the cycle after a pop makes count < DEPTH.
- cmd_* are sampled only at the accept edge. Changes at other times have no effect.
- No combinational path from cmd_valid or rsp_ready to any output except through cmd_ready's count term. cmd_ready depends only on registered state.

## Structure
- Package alu_pkg:
  - op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_AND=2'b11
  - RSP_W=5
  - state enum {IDLE, EXEC}
  - a pack_result function
- Sub-module alu_rsp_fifo: parameter DEPTH, width 8 ({err, op, data}), push/pop/count/full/empty. Instantiated once.
- The top module holds the FSM, operand registers, packing and error logic.

## Test plan
- After reset, cmd op=00 a=9 b=8 → alu_s=00, alu_a=9, alu_b=8 one cycle later; rsp_valid 2 cycles after accept, rsp_data=5'h11, rsp_err=0.
- op=01 a=5 b=3 → rsp_data=5'h12 (carry=1, 0010). op=01 a=3 b=5 → rsp_data=5'h0E.
- op=10 a=3 b=7 → rsp_data=5'b00001. Force agb=aeb=1 in the ALU model → rsp_err=1.
- Hold rsp_ready=0 with cmd_valid=1 continuously, DEPTH=2:
  - exactly 2 accepts, then cmd_ready stays 0
  - raise rsp_ready → responses pop in order, the next accept follows.
- op=11 a=4'hC b=4'hA → rsp_data=5'h08. Pop in the same cycle as a push with count==1 → count stays 1, order preserved.
- Assert rst_n=0 during EXEC with one entry buffered → rsp_valid=0 and cmd_ready=1 after reset; no stale response ever appears.
